// File: rtl/serial_compare_ctrl.sv
// Bit-serial word comparator controller: streams captured operands MSB first to an
// external 1-bit comparator. Optional early exit with SERIAL_COMPARE_EARLY_EXIT_EN.
module serial_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             cmp_in0,
    output logic             cmp_in1,
    input  logic             cmp_lower,
    input  logic             cmp_equal,
    input  logic             cmp_higher,
    output logic             busy,
    output logic             done,
    output logic             lower,
    output logic             equal,
    output logic             higher
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx_q;
    logic             scan_end_q;
    logic             diff_lt_q;
    logic             diff_gt_q;
    logic             busy_q;
    logic             done_q;
    logic             lower_q;
    logic             equal_q;
    logic             higher_q;

    logic [1:0]       bit_diff_s;
    logic             found_s;

    // Only a clean one-hot lower/higher marks a difference; anything else counts as equal.
    function automatic logic [1:0] decode_diff(input logic lo, input logic eq, input logic hi);
        case ({lo, eq, hi})
            3'b100:  return 2'b10;
            3'b001:  return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Comparator-side decode and operand bit steering.
    always_comb begin
        bit_diff_s = decode_diff(cmp_lower, cmp_equal, cmp_higher);
        found_s    = diff_lt_q | diff_gt_q;
        if (state_q == RUN && !scan_end_q) begin
            cmp_in0 = a_q[idx_q];
            cmp_in1 = b_q[idx_q];
        end else begin
            cmp_in0 = 1'b0;
            cmp_in1 = 1'b0;
        end
    end

    // Control FSM: the result of each bit is registered one edge after it is presented,
    // so the word result is published one cycle after the deciding bit was sampled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= {WIDTH{1'b0}};
            b_q        <= {WIDTH{1'b0}};
            idx_q      <= {IW{1'b0}};
            scan_end_q <= 1'b0;
            diff_lt_q  <= 1'b0;
            diff_gt_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lower_q    <= 1'b0;
            equal_q    <= 1'b0;
            higher_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q        <= a;
                        b_q        <= b;
                        idx_q      <= IW'(WIDTH - 1);
                        scan_end_q <= 1'b0;
                        diff_lt_q  <= 1'b0;
                        diff_gt_q  <= 1'b0;
                        lower_q    <= 1'b0;
                        equal_q    <= 1'b0;
                        higher_q   <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (scan_end_q || (EARLY_EXIT && found_s)) begin
                        lower_q  <= diff_lt_q;
                        higher_q <= diff_gt_q;
                        equal_q  <= ~found_s;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        if (!found_s) begin
                            {diff_lt_q, diff_gt_q} <= bit_diff_s;
                        end
                        if (idx_q == {IW{1'b0}}) begin
                            scan_end_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q - IW'(1);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign lower  = lower_q;
    assign equal  = equal_q;
    assign higher = higher_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl (WIDTH=8) with a behavioural 1-bit comparator.
module tb_serial_compare_ctrl;

`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cmp_in0, cmp_in1;
    logic       cmp_lower, cmp_equal, cmp_higher;
    logic       busy, done, lower, equal, higher;
    logic       cmp_bad = 1'b0;

    serial_compare_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .cmp_in0(cmp_in0), .cmp_in1(cmp_in1),
        .cmp_lower(cmp_lower), .cmp_equal(cmp_equal), .cmp_higher(cmp_higher),
        .busy(busy), .done(done), .lower(lower), .equal(equal), .higher(higher)
    );

    always #5 clk = ~clk;

    // External 1-bit comparator model; cmp_bad forces an illegal all-ones response.
    always_comb begin
        if (cmp_bad) begin
            {cmp_lower, cmp_equal, cmp_higher} = 3'b111;
        end else begin
            cmp_lower  = ~cmp_in0 & cmp_in1;
            cmp_equal  = ~(cmp_in0 ^ cmp_in1);
            cmp_higher = cmp_in0 & ~cmp_in1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] res;
        int         due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result and due cycle.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done=1 with no comparison pending (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("result_lower_equal_higher", int'({lower, equal, higher}), int'(mon_e.res));
                chk("done_cycle", cyc, mon_e.due);
            end
        end
    end

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] res,
                         input int lat, input bit expect_done);
        a = ia;
        b = ib;
        start = 1'b1;
        if (expect_done) q.push_back('{res, cyc + 1 + lat});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] res,
                       input int lat_early, input int lat_full);
        int lat;
        lat = EARLY ? lat_early : lat_full;
        issue(ia, ib, res, lat, 1'b1);
        repeat (lat + 1) @(posedge clk);
        #1;
    endtask

    logic [7:0] seq_a;
    logic [7:0] seq_b;
    int lat1;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({busy, done, lower, equal, higher, cmp_in0, cmp_in1}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Equal operands: full scan either way
        run(8'hA5, 8'hA5, 3'b010, 9, 9);
        // Difference in the MSB
        run(8'h80, 8'h7F, 3'b001, 2, 9);

        // Lower, differing only in the LSB, with MSB-first bit stream check
        seq_a = 8'h12;
        seq_b = 8'h13;
        issue(seq_a, seq_b, 3'b100, 9, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("cmp_in0_bit%0d", 7 - i), int'(cmp_in0), int'(seq_a[7 - i]));
            chk($sformatf("cmp_in1_bit%0d", 7 - i), int'(cmp_in1), int'(seq_b[7 - i]));
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("cmp_in_idle", int'({cmp_in0, cmp_in1}), 0);

        // Illegal comparator response counts as equal on every bit
        cmp_bad = 1'b1;
        run(8'h0F, 8'hF0, 3'b010, 9, 9);
        cmp_bad = 1'b0;

        // Start re-pulsed mid-scan with new operands is ignored
        lat1 = EARLY ? 3 : 9;
        issue(8'h40, 8'h20, 3'b001, lat1, 1'b1);
        @(posedge clk);
        #1;
        a = 8'h00;
        b = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (lat1 - 1) @(posedge clk);
        #1;

        // Back-to-back with start held high; second accepted in the IDLE cycle after DONE
        lat1 = EARLY ? 2 : 9;
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        q.push_back('{3'b001, cyc + 1 + lat1});
        @(posedge clk);
        #1;
        a = 8'h00;
        b = 8'h01;
        q.push_back('{3'b100, cyc + lat1 + 2 + 9});
        repeat (lat1 + 1) @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("cleared_on_accept", int'({busy, lower, equal, higher}), int'(4'b1000));
        repeat (10) @(posedge clk);
        #1;

        // Reset in cycle 4 of a scan abandons it without a done pulse
        issue(8'h55, 8'h55, 3'b010, 9, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_reset_outputs", int'({busy, done, lower, equal, higher, cmp_in0, cmp_in1}), 0);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        run(8'h01, 8'h00, 3'b001, 9, 9);

        repeat (5) @(posedge clk);
        #1;
        chk("pending_results_left", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
